// File: rtl/clock_pkg.sv
// ============================================================================
// Module : clock_pkg
// Brief  : Shared timing constants and digit limits for the stopwatch and
//          time-of-day register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clock_pkg;

  localparam int TICK_DIV_DEFAULT = 500000;
  localparam int NUM_DIGITS       = 6;

  localparam int HUND_ONES_MAX = 9;
  localparam int HUND_TENS_MAX = 9;
  localparam int SEC_ONES_MAX  = 9;
  localparam int SEC_TENS_MAX  = 5;
  localparam int MIN_ONES_MAX  = 9;
  localparam int MIN_TENS_MAX  = 5;

  typedef logic [3:0] bcd_t;

  // Digit index 0 is hundredths units, 5 is minutes tens.
  function automatic int digit_max(input int idx);
    case (idx)
      0:       return HUND_ONES_MAX;
      1:       return HUND_TENS_MAX;
      2:       return SEC_ONES_MAX;
      3:       return SEC_TENS_MAX;
      4:       return MIN_ONES_MAX;
      default: return MIN_TENS_MAX;
    endcase
  endfunction

  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module : bcd_digit
// Brief  : One BCD counter digit with wrap at MAX and ripple carry output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import clock_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t digit,
  output logic carry_out
);

  bcd_t digit_q;
  bcd_t digit_d;
  logic w_at_max;

  // >= rather than == so the digit can never escape above its limit.
  assign w_at_max  = (digit_q >= 4'(MAX));
  assign carry_out = inc && w_at_max;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = w_at_max ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_cntr.sv
// ============================================================================
// Module : stopwatch_cntr
// Brief  : MM:SS.hh stopwatch: prescaler plus six chained BCD digits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stopwatch_cntr
  import clock_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_sw,
  input  logic       clr_sw,
  output logic [3:0] hund_ones,
  output logic [3:0] hund_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       rollover
);

  localparam int            PW         = presc_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       presc_q;
  logic [PW-1:0]       presc_d;
  logic                rollover_q;
  logic                rollover_d;
  logic                w_tick;
  logic [NUM_DIGITS:0] w_carry;
  bcd_t                w_digit [NUM_DIGITS];

  assign w_tick = enable_sw && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (clr_sw) begin
      presc_d = '0;
    end else if (enable_sw) begin
      presc_d = w_tick ? '0 : presc_q + 1'b1;
    end
  end

  // Clear beats a coincident tick, so the carry chain never starts on clear.
  assign w_carry[0] = w_tick && !clr_sw;
  assign rollover_d = w_carry[NUM_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      rollover_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      rollover_q <= rollover_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit #(
        .MAX(digit_max(i))
      ) u_digit (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_sw),
        .inc      (w_carry[i]),
        .digit    (w_digit[i]),
        .carry_out(w_carry[i+1])
      );
    end
  endgenerate

  assign hund_ones = w_digit[0];
  assign hund_tens = w_digit[1];
  assign sec_ones  = w_digit[2];
  assign sec_tens  = w_digit[3];
  assign min_ones  = w_digit[4];
  assign min_tens  = w_digit[5];
  assign rollover  = rollover_q;

endmodule

`default_nettype wire

// File: doc/stopwatch_cntr.md
STOPWATCH_CNTR -- requirements
Module: stopwatch_cntr

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, meaning clk cycles per 1/100 s (500000 gives 10 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  50MHz clock; all flops rise-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable_sw  input  1  level from the clock control SM; high = stopwatch runs.
REQ-005 SHALL have port clr_sw  input  1  single-cycle pulse; zeroes the stopwatch.
REQ-006 SHALL have port hund_ones  output  4  BCD hundredths units, 0-9.
REQ-007 SHALL have port hund_tens  output  4  BCD hundredths tens, 0-9.
REQ-008 SHALL have port sec_ones  output  4  BCD seconds units, 0-9.
REQ-009 SHALL have port sec_tens  output  4  BCD seconds tens, 0-5.
REQ-010 SHALL have port min_ones  output  4  BCD minutes units, 0-9.
REQ-011 SHALL have port min_tens  output  4  BCD minutes tens, 0-5.
REQ-012 SHALL have port rollover  output  1  one-cycle pulse when 59:59.99 wraps to 00:00.00.

Function
REQ-013 SHALL hold a prescaler counter, width ceil(log2(TICK_DIV)), that increments each cycle while enable_sw=1.
REQ-014 SHALL assert an internal tick for exactly one cycle when the prescaler equals TICK_DIV-1 and enable_sw=1; the prescaler returns to 0 on that cycle.
REQ-015 SHALL hold prescaler and all digits unchanged while enable_sw=0, so stop/restart resumes mid-interval.
REQ-016 SHALL advance hund_ones by 1 on every tick; each digit wraps to 0 and carries to the next digit when it is at its maximum and receives a carry.
REQ-017 SHALL use digit maxima of 9,9,9,5,9,5 for hund_ones, hund_tens, sec_ones, sec_tens, min_ones, min_tens.
REQ-018 SHALL update every digit in the same clock edge that ripples the carry: one cycle latency from tick to new digits, no multi-cycle carry propagation.
REQ-019 SHALL wrap 59:59.99 to 00:00.00 on a tick and assert rollover in the cycle the outputs show 00:00.00.
REQ-020 SHALL, on clr_sw=1, set all digits and the prescaler to 0 on the next edge, whether or not enable_sw is high.
REQ-021 SHALL give clr_sw priority over a coincident tick; no increment occurs and rollover stays 0 in that cycle.
REQ-022 SHALL never drive a digit above its maximum; digits are registered outputs with no combinational path from inputs.

Reset
REQ-023 SHALL, while rst_n=0, force all digits to 0, prescaler to 0, and rollover to 0, independent of clk.
REQ-024 SHALL, on reset assertion mid-count, abandon any partial interval; counting restarts from a full TICK_DIV interval after release.

Structure
REQ-025 SHALL take TICK_DIV default and the digit maxima constants from shared package clock_pkg, also used by the time-of-day register.
REQ-026 SHALL instantiate six copies of sub-module bcd_digit (parameter MAX; ports clk, rst_n, clr, inc, digit, carry_out), chained through carry_out.
REQ-027 SHALL keep the prescaler in stopwatch_cntr itself, not in bcd_digit.

Verification (TICK_DIV=4 in bench)
REQ-028 SHALL cover: reset release, enable_sw=1 for 40 cycles -> hund_tens=1, hund_ones=0 (10 ticks).
REQ-029 SHALL cover: run 2 cycles, enable_sw=0 for 20 cycles, re-enable -> first tick exactly 2 cycles later; digits frozen during stop.
REQ-030 SHALL cover: preload/run to 00:09.99, one tick -> 00:10.00 in one cycle.
REQ-031 SHALL cover: run to 59:59.99, one tick -> 00:00.00 with rollover high for exactly 1 cycle.
REQ-032 SHALL cover: clr_sw on the same cycle as a tick at 00:00.05 -> 00:00.00, prescaler 0, no rollover.
REQ-033 SHALL cover: rst_n asserted low mid-interval asynchronously -> all outputs 0 before the next clk edge.
